fu_mul_arbiter: RTL

Shares one pipelined 32x32 multiplier between NREQ issue requesters (reservation stations / issue slots) in the dynamic-scheduling core. It arbitrates requests round-robin and feeds operands to the multiplier. It tracks in-flight operations by requester id and tag, then buffers products in a result FIFO drained onto the common data bus under a valid/ready handshake. Credit-based issue control guarantees that no result is ever dropped.

---
 rtl/fu_mul_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fu_mul_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fu_mul_arbiter : round-robin share of one pipelined 32x32 multiplier with
//                  credit-protected in-order result FIFO onto the CDB
// Revision 1.0
// ---------------------------------------------------------------------------
module fu_mul_arbiter #(
  parameter int NREQ  = 2,
  parameter int LAT   = 7,
  parameter int TAGW  = 4,
  parameter int DEPTH = 8,
  localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [32*NREQ-1:0]     req_a,
  input  logic [32*NREQ-1:0]     req_b,
  input  logic [TAGW*NREQ-1:0]   req_tag,
  output logic [31:0]            mul_a,
  output logic [31:0]            mul_b,
  input  logic [63:0]            mul_p,
  output logic                   cdb_valid,
  input  logic                   cdb_ready,
  output logic [31:0]            cdb_res,
  output logic [SRCW-1:0]        cdb_src,
  output logic [TAGW-1:0]        cdb_tag
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]     res;
    logic [SRCW-1:0] src;
    logic [TAGW-1:0] tag;
  } entry_t;

  logic [31:0]     w_a_arr   [NREQ];
  logic [31:0]     w_b_arr   [NREQ];
  logic [TAGW-1:0] w_tag_arr [NREQ];

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_unpack
      assign w_a_arr[g]   = req_a[32*g +: 32];
      assign w_b_arr[g]   = req_b[32*g +: 32];
      assign w_tag_arr[g] = req_tag[TAGW*g +: TAGW];
    end
  endgenerate

  logic [SRCW-1:0] r_ptr;
  logic [CW-1:0]   r_outstanding;
  logic [SRCW-1:0] w_idx;
  logic [SRCW-1:0] w_sel;
  logic            w_found;
  logic            w_credit;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;

  // Round-robin scan starting at r_ptr; the first valid requester wins.
  always_comb begin
    w_idx   = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = SRCW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_credit  = !rst && (r_outstanding != CW'(DEPTH));
  assign w_accept  = w_found && w_credit;
  assign req_ready = w_accept ? (NREQ'(1) << w_sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_sel == SRCW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
      mul_a <= w_a_arr[w_sel];
      mul_b <= w_b_arr[w_sel];
    end
  end

  // Credits cover both in-flight products and buffered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Stage j holds the op whose operands entered the multiplier j cycles ago;
  // stage LAT lines up with its product on mul_p.
  logic [LAT:0]    r_vld;
  logic [SRCW-1:0] r_src [LAT+1];
  logic [TAGW-1:0] r_tag [LAT+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[LAT-1:0], w_accept};
    end
  end

  always_ff @(posedge clk) begin
    r_src[0] <= w_sel;
    r_tag[0] <= w_tag_arr[w_sel];
    for (int j = 1; j <= LAT; j++) begin
      r_src[j] <= r_src[j-1];
      r_tag[j] <= r_tag[j-1];
    end
  end

  assign w_push = r_vld[LAT];

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  entry_t        w_head;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{res: mul_p[31:0], src: r_src[LAT], tag: r_tag[LAT]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign cdb_valid = (r_count != '0);
  assign w_pop     = cdb_valid && cdb_ready;
  assign w_head    = r_mem[r_rptr];
  assign cdb_res   = cdb_valid ? w_head.res : '0;
  assign cdb_src   = cdb_valid ? w_head.src : '0;
  assign cdb_tag   = cdb_valid ? w_head.tag : '0;

  // Only the low half of the product is forwarded.
  logic w_unused_hi;
  assign w_unused_hi = ^mul_p[63:32];

endmodule
`default_nettype wire
